// File: rtl/aes_round_scheduler.sv
// aes_round_scheduler
//   Control FSM for an iterative AES-128 round datapath. It accepts one block
//   on a valid/ready handshake. It then launches one datapath token per round
//   and tracks the token's return on the pipeline empty flag. It drives Rcon
//   and the last-round MixColumns bypass, and presents completion on a
//   valid/ready output.
//   Optional feature macro: AES_SCHED_STATS_EN adds the blk_count port, a
//   saturating count of completed blocks.
module aes_round_scheduler #(
    parameter int NUM_ROUNDS = 10,  // rounds per block, 1..15
    parameter int ROUND_LAT  = 4,   // datapath register depth, >= 1
    parameter int WD_W       = 5    // must hold 2*ROUND_LAT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        dp_load,
    output logic        dp_empty,
    input  logic        dp_empty_ret,
    output logic        dp_last_round,
    output logic [7:0]  dp_rcon,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        err
`ifdef AES_SCHED_STATS_EN
    ,
    output logic [15:0] blk_count
`endif
);

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [WD_W-1:0] WD_DRAIN   = WD_W'(ROUND_LAT);
    localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(2 * ROUND_LAT);
    localparam logic [3:0]      ROUND_LAST = 4'(NUM_ROUNDS);
    localparam logic [7:0]      RCON_FIRST = 8'h01;

    state_t          state, state_next;
    logic [3:0]      round_next;
    logic [7:0]      rcon_next;
    logic [WD_W-1:0] wd, wd_next, wd_inc;
    logic            err_next;

    // Multiply by x in GF(2^8): the Rcon step between consecutive rounds.
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    assign wd_inc = wd + WD_W'(1);

    // Next-state, round/Rcon bookkeeping and watchdog decisions.
    always_comb begin
        // NOTE: defaults first so every path assigns every target and no latch is inferred.
        state_next = state;
        round_next = round_idx;
        rcon_next  = dp_rcon;
        wd_next    = wd;
        err_next   = err;
        case (state)
            S_DRAIN: begin
                // Stale tokens from an interrupted block flush out here; their
                // return is deliberately not observed.
                if (wd == WD_DRAIN) begin
                    state_next = S_IDLE;
                    wd_next    = '0;
                end else begin
                    wd_next = wd_inc;
                end
            end
            S_IDLE: begin
                if (in_valid && !err) begin
                    state_next = S_LOAD;
                    round_next = 4'd1;
                    rcon_next  = RCON_FIRST;
                end
            end
            S_LOAD: begin
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                wd_next = '0;
                if (!dp_empty_ret) begin
                    // A token arriving while we launch ours cannot be ours.
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                    round_next = 4'd0;
                    rcon_next  = RCON_FIRST;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                wd_next = wd_inc;
                if (!dp_empty_ret) begin
                    if (round_idx < ROUND_LAST) begin
                        round_next = round_idx + 4'd1;
                        rcon_next  = xtime(dp_rcon);
                        state_next = S_ISSUE;
                    end else begin
                        state_next = S_DONE;
                    end
                end else if (wd_inc == WD_LIMIT) begin
                    // Token lost: give up on the block and lock out new ones.
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                    round_next = 4'd0;
                    rcon_next  = RCON_FIRST;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                    round_next = 4'd0;
                    rcon_next  = RCON_FIRST;
                end
            end
            default: begin
                state_next = S_DRAIN;
                wd_next    = '0;
            end
        endcase
    end

    // State and bookkeeping registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments make every register update from the same pre-edge values.
        if (!reset_n) begin
            state     <= S_DRAIN;
            round_idx <= 4'd0;
            dp_rcon   <= RCON_FIRST;
            wd        <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            round_idx <= round_next;
            dp_rcon   <= rcon_next;
            wd        <= wd_next;
            err       <= err_next;
        end
    end

    // Outputs are pure decodes of registered state.
    assign in_ready      = (state == S_IDLE) && !err;
    assign out_valid     = (state == S_DONE);
    assign dp_load       = (state == S_LOAD);
    assign dp_empty      = (state != S_ISSUE);
    assign dp_last_round = (round_idx == ROUND_LAST);
    assign busy          = (state != S_IDLE);

`ifdef AES_SCHED_STATS_EN
    // Saturating count of blocks handed to the consumer.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            blk_count <= 16'd0;
        end else if (out_valid && out_ready && (blk_count != 16'hFFFF)) begin
            blk_count <= blk_count + 16'd1;
        end
    end
`endif

endmodule
